// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add scheduler.
// State encoding and requester count.
package serial_add_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/dataflow_adder.sv
// One-bit full adder used as the serial datapath.
// Pure dataflow, no state.
module dataflow_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester round-robin front end around a
// bit-serial adder, one sum bit per cycle.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [N-1:0]    a0,
  input  logic [N-1:0]    b0,
  input  logic [N-1:0]    a1,
  input  logic [N-1:0]    b1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_sum,
  output logic            rsp_cout,
  output logic            rsp_id,
  output logic            busy
);

  state_t             state;
  logic [N-1:0]       sa;
  logic [N-1:0]       sb;
  logic [N-1:0]       res;
  logic               c;
  logic [$clog2(N):0] cnt;
  logic               rid;
  logic               last;
  logic [NREQ-1:0]    gnt;
  logic               hs;
  logic               s;
  logic               co;

  dataflow_adder u_add (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (c),
    .s    (s),
    .cout (co)
  );

  // Round-robin pick: a tie goes away from the last winner.
  always_comb begin
    gnt = '0;
    if (req_valid == 2'b11)
      gnt = last ? 2'b01 : 2'b10;
    else
      gnt = req_valid;
  end

  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  // Control FSM and serial datapath; outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      rid       <= 1'b0;
      last      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            sa    <= gnt[1] ? a1 : a0;
            sb    <= gnt[1] ? b1 : b0;
            res   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            rid   <= gnt[1];
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {s, res[N-1:1]};
          c   <= co;
          cnt <= cnt + 1'b1;
          if (int'(cnt) == N - 1) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= {s, res[N-1:1]};
            rsp_cout  <= co;
            rsp_id    <= rid;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
            last      <= rid;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
